// File: rtl/uart_pkg.sv
// Shared UART definitions: block-checksum state encoding and default byte width.
package uart_pkg;

  // Default width of a received UART byte.
  localparam int UART_N_DATA_BITS = 8;

  // Block checksum flow: collect bytes, add them up, hand the result over.
  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SUM    = 2'd1,
    RESULT = 2'd2
  } blk_state_t;

endpackage

// File: rtl/uart_byte_buffer.sv
// Small byte store for one block: synchronous write, combinational read
// so the summing loop can consume one entry per cycle with no read latency.
module uart_byte_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port: contents need no reset, every entry is rewritten before it is read.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = mem[i_rd_addr];

endmodule

// File: rtl/uart_block_checksum.sv
// Collects BLOCK_LEN bytes from the UART receiver, sums them one entry per
// cycle, and offers the wrapped sum to the transmitter on a valid/ready port.
//
// Output handshake: o_sum_valid rises once the sum is ready and stays high,
// with o_sum frozen, until i_sum_ready is sampled high on a clock edge while
// o_sum_valid is high; that edge is the transfer and o_sum_valid drops on the
// following cycle. i_sum_ready has no effect at any other time.
module uart_block_checksum
  import uart_pkg::*;
#(
  parameter int N_DATA_BITS = UART_N_DATA_BITS,
  parameter int BLOCK_LEN   = 16,
  parameter int SUM_WIDTH   = 8,
  localparam int CW         = $clog2(BLOCK_LEN + 1),
  localparam int PW         = $clog2(BLOCK_LEN)
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic [N_DATA_BITS-1:0] i_data,
  input  logic                   i_data_valid,
  input  logic                   i_sum_ready,
  output logic [SUM_WIDTH-1:0]   o_sum,
  output logic                   o_sum_valid,
  output logic [CW-1:0]          o_byte_count,
  output logic                   o_busy,
  output logic                   o_overrun
);

  localparam logic [PW-1:0] LAST_PTR   = PW'(BLOCK_LEN - 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(BLOCK_LEN - 1);

  blk_state_t           state_q, state_d;
  logic                 valid_prev_q, valid_prev_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [SUM_WIDTH-1:0] acc_q, acc_d;
  logic [SUM_WIDTH-1:0] sum_q, sum_d;
  logic                 sum_valid_q, sum_valid_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 busy_q, busy_d;
  logic                 overrun_q, overrun_d;

  logic                   byte_event;
  logic                   buf_we;
  logic [N_DATA_BITS-1:0] rd_data;
  logic [SUM_WIDTH-1:0]   addend;

  // A held-high valid level produces a single byte event on its rising edge.
  assign byte_event = i_data_valid & ~valid_prev_q;

  // Size cast zero-extends (or truncates) the stored byte to the accumulator width.
  assign addend = SUM_WIDTH'(rd_data);

  uart_byte_buffer #(
    .DATA_W (N_DATA_BITS),
    .DEPTH  (BLOCK_LEN)
  ) u_buf (
    .i_clk     (i_clk),
    .i_wr_en   (buf_we),
    .i_wr_addr (wr_ptr_q),
    .i_wr_data (i_data),
    .i_rd_addr (rd_ptr_q),
    .o_rd_data (rd_data)
  );

  // State and datapath registers; a reset discards any partial block or pending sum.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q      <= FILL;
      valid_prev_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      acc_q        <= '0;
      sum_q        <= '0;
      sum_valid_q  <= 1'b0;
      count_q      <= '0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_prev_q <= valid_prev_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      acc_q        <= acc_d;
      sum_q        <= sum_d;
      sum_valid_q  <= sum_valid_d;
      count_q      <= count_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  // Next-state logic: fill the buffer, sum it, then hold the result until taken.
  always_comb begin
    state_d      = state_q;
    valid_prev_d = i_data_valid;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    acc_d        = acc_q;
    sum_d        = sum_q;
    sum_valid_d  = sum_valid_q;
    count_d      = count_q;
    busy_d       = busy_q;
    overrun_d    = overrun_q;
    buf_we       = 1'b0;

    case (state_q)
      FILL: begin
        if (byte_event) begin
          buf_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PW'(1);
          count_d  = count_q + CW'(1);
          if (count_q == LAST_COUNT) begin
            state_d  = SUM;
            rd_ptr_d = '0;
            acc_d    = '0;
            busy_d   = 1'b1;
          end
        end
      end

      SUM: begin
        // The buffer cannot accept bytes while it is being read out.
        if (byte_event) begin
          overrun_d = 1'b1;
        end
        acc_d    = acc_q + addend;
        rd_ptr_d = rd_ptr_q + PW'(1);
        if (rd_ptr_q == LAST_PTR) begin
          state_d     = RESULT;
          sum_d       = acc_q + addend;
          sum_valid_d = 1'b1;
        end
      end

      RESULT: begin
        // A byte arriving on the transfer cycle is also dropped.
        if (byte_event) begin
          overrun_d = 1'b1;
        end
        if (i_sum_ready) begin
          state_d     = FILL;
          sum_valid_d = 1'b0;
          wr_ptr_d    = '0;
          count_d     = '0;
          busy_d      = 1'b0;
        end
      end

      default: begin
        state_d     = FILL;
        sum_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  assign o_sum        = sum_q;
  assign o_sum_valid  = sum_valid_q;
  assign o_byte_count = count_q;
  assign o_busy       = busy_q;
  assign o_overrun    = overrun_q;

endmodule
